// File: rtl/fc_layer_sequencer.sv
// ============================================================================
// fc_layer_sequencer : streams node/weight pairs into the FC MAC core, one
// output neuron at a time, and collects one accumulated result per neuron.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fc_layer_sequencer #(
  parameter int IN_DATA_WIDTH = 8,
  parameter int NODE_ADDR_W   = 10,
  parameter int WEGT_ADDR_W   = 16,
  parameter int CNT_W         = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_run,
  input  logic [CNT_W-1:0]           i_num_in,
  input  logic [CNT_W-1:0]           i_num_out,
  output logic                       o_idle,
  output logic                       o_done,
  output logic [NODE_ADDR_W-1:0]     o_node_addr,
  output logic                       o_node_rd,
  input  logic [IN_DATA_WIDTH-1:0]   i_node_data,
  output logic [WEGT_ADDR_W-1:0]     o_wegt_addr,
  output logic                       o_wegt_rd,
  input  logic [IN_DATA_WIDTH-1:0]   i_wegt_data,
  output logic                       o_core_run,
  output logic                       o_core_valid,
  output logic [IN_DATA_WIDTH-1:0]   o_core_node,
  output logic [IN_DATA_WIDTH-1:0]   o_core_wegt,
  input  logic                       i_core_valid,
  input  logic [4*IN_DATA_WIDTH-1:0] i_core_result,
  output logic                       o_result_valid,
  output logic [4*IN_DATA_WIDTH-1:0] o_result,
  output logic [CNT_W-1:0]           o_result_idx
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           n_q, n_d;
  logic [CNT_W-1:0]           m_q, m_d;
  logic [CNT_W-1:0]           in_idx_q, in_idx_d;
  logic [CNT_W-1:0]           out_idx_q, out_idx_d;
  logic [CNT_W-1:0]           rx_cnt_q, rx_cnt_d;
  logic [WEGT_ADDR_W-1:0]     wadr_q, wadr_d;
  logic                       core_valid_q, core_valid_d;
  logic [4*IN_DATA_WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0]           result_idx_q, result_idx_d;
  logic                       result_valid_q, result_valid_d;
  logic                       done_q, done_d;
  logic                       feed;
  logic                       core_run;

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    m_d            = m_q;
    in_idx_d       = in_idx_q;
    out_idx_d      = out_idx_q;
    rx_cnt_d       = rx_cnt_q;
    wadr_d         = wadr_q;
    core_valid_d   = 1'b0;
    result_d       = result_q;
    result_idx_d   = result_idx_q;
    result_valid_d = 1'b0;
    done_d         = 1'b0;
    feed           = 1'b0;
    core_run       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_run) begin
          n_d       = i_num_in;
          m_d       = i_num_out;
          in_idx_d  = '0;
          out_idx_d = '0;
          wadr_d    = '0;
          state_d   = (i_num_in == '0 || i_num_out == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        core_run = 1'b1;
        rx_cnt_d = '0;
        state_d  = S_FEED;
      end
      S_FEED: begin
        feed         = 1'b1;
        core_valid_d = 1'b1;
        wadr_d       = wadr_q + 1'b1;
        if (in_idx_q == n_q - 1'b1) begin
          in_idx_d = '0;
          state_d  = S_DRAIN;
        end else begin
          in_idx_d = in_idx_q + 1'b1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: ;
    endcase

    // The core returns one valid per pair; the Nth one carries the full sum.
    if ((state_q == S_FEED || state_q == S_DRAIN) && i_core_valid) begin
      if (rx_cnt_q == n_q - 1'b1) begin
        result_d       = i_core_result;
        result_idx_d   = out_idx_q;
        result_valid_d = 1'b1;
        if (out_idx_q == m_q - 1'b1) begin
          state_d = S_DONE;
        end else begin
          out_idx_d = out_idx_q + 1'b1;
          state_d   = S_CLEAR;
        end
      end else begin
        rx_cnt_d = rx_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      n_q            <= '0;
      m_q            <= '0;
      in_idx_q       <= '0;
      out_idx_q      <= '0;
      rx_cnt_q       <= '0;
      wadr_q         <= '0;
      core_valid_q   <= 1'b0;
      result_q       <= '0;
      result_idx_q   <= '0;
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      m_q            <= m_d;
      in_idx_q       <= in_idx_d;
      out_idx_q      <= out_idx_d;
      rx_cnt_q       <= rx_cnt_d;
      wadr_q         <= wadr_d;
      core_valid_q   <= core_valid_d;
      result_q       <= result_d;
      result_idx_q   <= result_idx_d;
      result_valid_q <= result_valid_d;
      done_q         <= done_d;
    end
  end

  // Addresses and pass-through data are gated so idle outputs read as zero.
  assign o_idle         = (state_q == S_IDLE);
  assign o_done         = done_q;
  assign o_node_rd      = feed;
  assign o_wegt_rd      = feed;
  assign o_node_addr    = feed ? NODE_ADDR_W'(in_idx_q) : '0;
  assign o_wegt_addr    = feed ? wadr_q : '0;
  assign o_core_run     = core_run;
  assign o_core_valid   = core_valid_q;
  assign o_core_node    = core_valid_q ? i_node_data : '0;
  assign o_core_wegt    = core_valid_q ? i_wegt_data : '0;
  assign o_result_valid = result_valid_q;
  assign o_result       = result_q;
  assign o_result_idx   = result_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_fc_layer_sequencer.sv
// ============================================================================
// tb_fc_layer_sequencer : directed bench with memory and MAC core models.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fc_layer_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_run = 1'b0;
  logic [9:0]  i_num_in = '0;
  logic [9:0]  i_num_out = '0;
  logic        o_idle, o_done;
  logic [9:0]  o_node_addr;
  logic        o_node_rd;
  logic [7:0]  i_node_data;
  logic [15:0] o_wegt_addr;
  logic        o_wegt_rd;
  logic [7:0]  i_wegt_data;
  logic        o_core_run, o_core_valid;
  logic [7:0]  o_core_node, o_core_wegt;
  logic        i_core_valid;
  logic [31:0] i_core_result;
  logic        o_result_valid;
  logic [31:0] o_result;
  logic [9:0]  o_result_idx;

  fc_layer_sequencer dut (
    .clk(clk), .reset(reset), .i_run(i_run), .i_num_in(i_num_in), .i_num_out(i_num_out),
    .o_idle(o_idle), .o_done(o_done),
    .o_node_addr(o_node_addr), .o_node_rd(o_node_rd), .i_node_data(i_node_data),
    .o_wegt_addr(o_wegt_addr), .o_wegt_rd(o_wegt_rd), .i_wegt_data(i_wegt_data),
    .o_core_run(o_core_run), .o_core_valid(o_core_valid),
    .o_core_node(o_core_node), .o_core_wegt(o_core_wegt),
    .i_core_valid(i_core_valid), .i_core_result(i_core_result),
    .o_result_valid(o_result_valid), .o_result(o_result), .o_result_idx(o_result_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Synchronous-read memories
  logic signed [7:0] node_mem [256];
  logic signed [7:0] wegt_mem [256];
  always @(posedge clk) begin
    if (o_node_rd) i_node_data <= node_mem[o_node_addr[7:0]];
    if (o_wegt_rd) i_wegt_data <= wegt_mem[o_wegt_addr[7:0]];
  end

  // MAC core: result/valid two cycles after each accepted pair
  logic        s1_v;
  int          s1_p;
  int          acc;
  always @(posedge clk) begin
    if (reset) begin
      s1_v <= 1'b0; i_core_valid <= 1'b0; acc <= 0; i_core_result <= '0;
    end else begin
      s1_v <= o_core_valid;
      s1_p <= int'($signed(o_core_node)) * int'($signed(o_core_wegt));
      i_core_valid <= s1_v;
      if (o_core_run) acc <= 0;
      else if (s1_v) begin
        acc <= acc + s1_p;
        i_core_result <= 32'(acc + s1_p);
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  int rd_cnt = 0, cv_cnt = 0, run_cnt = 0, done_cnt = 0, res_cnt = 0;
  int run_cyc = 0, done_cyc = 0, last_feed = 0;
  int cur_n = 0, exp_in = 0, exp_w = 0;
  logic [31:0] res_val [16];
  int          res_idx [16];
  int          res_lat [16];
  int          res_cyc [16];

  always @(negedge clk) begin
    if (!reset) begin
      if (i_run && o_idle) begin
        run_cyc = cyc; cur_n = int'(i_num_in); exp_in = 0; exp_w = 0;
      end
      if (o_node_rd) begin
        check("node_addr", 32'(o_node_addr), 32'(exp_in));
        check("wegt_addr", 32'(o_wegt_addr), 32'(exp_w));
        exp_in = (exp_in + 1 == cur_n) ? 0 : exp_in + 1;
        exp_w++;
        rd_cnt++;
        last_feed = cyc;
      end
      if (o_core_valid) cv_cnt++;
      if (o_core_run) run_cnt++;
      if (o_result_valid && res_cnt < 16) begin
        res_val[res_cnt] = o_result;
        res_idx[res_cnt] = int'(o_result_idx);
        res_lat[res_cnt] = cyc - last_feed;
        res_cyc[res_cnt] = cyc;
        res_cnt++;
      end
      if (o_done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start(input int n, input int m);
    i_run = 1'b1; i_num_in = 10'(n); i_num_out = 10'(m);
    tick();
    i_run = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int t;
    t = 0;
    while (done_cnt == base && t < 400) begin tick(); t++; end
    if (done_cnt == base) check("done_timeout", 32'(done_cnt), 32'(base + 1));
  endtask

  task automatic wait_rd();
    int t;
    t = 0;
    while (!o_node_rd && t < 20) begin tick(); t++; end
    if (!o_node_rd) check("rd_timeout", 32'(o_node_rd), 32'd1);
  endtask

  task automatic check_res(input int i, input int val, input int idx);
    check("result", res_val[i], 32'(val));
    check("result_idx", 32'(res_idx[i]), 32'(idx));
    check("result_latency", 32'(res_lat[i]), 32'd4);
  endtask

  int b_res, b_done, b_rd, b_run, b_cv;

  initial begin
    for (int i = 0; i < 256; i++) begin node_mem[i] = '0; wegt_mem[i] = '0; end
    repeat (3) tick();
    check("rst_idle", 32'(o_idle), 32'd1);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_rd", 32'(o_node_rd), 32'd0);
    check("rst_rv", 32'(o_result_valid), 32'd0);
    check("rst_result", o_result, 32'd0);
    reset = 1'b0;
    tick();

    // N=3, M=2
    node_mem[0] = 1; node_mem[1] = 2; node_mem[2] = 3;
    wegt_mem[0] = 4; wegt_mem[1] = 5; wegt_mem[2] = 6;
    wegt_mem[3] = -1; wegt_mem[4] = -2; wegt_mem[5] = -3;
    b_res = res_cnt; b_done = done_cnt;
    start(3, 2);
    wait_done(b_done);
    check("t1_count", 32'(res_cnt - b_res), 32'd2);
    check_res(b_res, 32, 0);
    check_res(b_res + 1, -14, 1);
    check("t1_done_lat", 32'(done_cyc - res_cyc[b_res + 1]), 32'd1);
    check("t1_idle", 32'(o_idle), 32'd1);
    tick();

    // N=4, M=1, all -128
    for (int i = 0; i < 4; i++) begin node_mem[i] = -128; wegt_mem[i] = -128; end
    b_res = res_cnt; b_done = done_cnt; b_cv = cv_cnt;
    start(4, 1);
    wait_done(b_done);
    check("t2_count", 32'(res_cnt - b_res), 32'd1);
    check_res(b_res, 65536, 0);
    check("t2_core_valid", 32'(cv_cnt - b_cv), 32'd4);
    tick();

    // N=5, M=0
    b_res = res_cnt; b_done = done_cnt; b_rd = rd_cnt; b_run = run_cnt;
    start(5, 0);
    wait_done(b_done);
    check("t3_reads", 32'(rd_cnt - b_rd), 32'd0);
    check("t3_core_run", 32'(run_cnt - b_run), 32'd0);
    check("t3_results", 32'(res_cnt - b_res), 32'd0);
    check("t3_done_lat", 32'(done_cyc - run_cyc), 32'd2);
    tick();

    // N=3, M=3 with an ignored i_run during FEED
    node_mem[0] = 1; node_mem[1] = 2; node_mem[2] = 3;
    wegt_mem[0] = 1;  wegt_mem[1] = 1; wegt_mem[2] = 1;
    wegt_mem[3] = 2;  wegt_mem[4] = 0; wegt_mem[5] = -1;
    wegt_mem[6] = -3; wegt_mem[7] = 4; wegt_mem[8] = 5;
    b_res = res_cnt; b_done = done_cnt; b_rd = rd_cnt;
    start(3, 3);
    wait_rd();
    start(2, 1);
    wait_done(b_done);
    check("t4_count", 32'(res_cnt - b_res), 32'd3);
    check_res(b_res, 6, 0);
    check_res(b_res + 1, -1, 1);
    check_res(b_res + 2, 20, 2);
    check("t4_reads", 32'(rd_cnt - b_rd), 32'd9);
    tick();

    // Reset in the middle of FEED, then N=2, M=1
    start(8, 2);
    wait_rd();
    tick(); tick();
    reset = 1'b1;
    tick();
    check("rst_mid_idle", 32'(o_idle), 32'd1);
    check("rst_mid_rd", 32'({o_node_rd, o_wegt_rd, o_core_run, o_core_valid, o_done, o_result_valid}), 32'd0);
    check("rst_mid_addr", 32'({o_node_addr, o_wegt_addr}), 32'd0);
    check("rst_mid_data", 32'({o_core_node, o_core_wegt, o_result_idx}), 32'd0);
    check("rst_mid_result", o_result, 32'd0);
    b_res = res_cnt; b_done = done_cnt;
    tick(); tick();
    reset = 1'b0;
    repeat (10) tick();
    check("rst_no_done", 32'(done_cnt - b_done), 32'd0);
    check("rst_no_result", 32'(res_cnt - b_res), 32'd0);
    node_mem[0] = 3; node_mem[1] = -4;
    wegt_mem[0] = 5; wegt_mem[1] = 6;
    start(2, 1);
    wait_done(b_done);
    check("t5_count", 32'(res_cnt - b_res), 32'd1);
    check_res(b_res, -9, 0);
    tick();

    // N=1, M=3
    node_mem[0] = 2;
    wegt_mem[0] = 7; wegt_mem[1] = -7; wegt_mem[2] = 0;
    b_res = res_cnt; b_done = done_cnt; b_run = run_cnt;
    start(1, 3);
    wait_done(b_done);
    check("t6_count", 32'(res_cnt - b_res), 32'd3);
    check_res(b_res, 14, 0);
    check_res(b_res + 1, -14, 1);
    check_res(b_res + 2, 0, 2);
    check("t6_core_run", 32'(run_cnt - b_run), 32'd3);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
